// File: rtl/rng_pkg.sv
// Shared types and constants for the LFSR request arbiter.
// The bench LFSR model uses RNG_SEED as its reset value.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } rng_state_t;

    localparam int RNG_WIDTH  = 13;
    localparam int RNG_SHIFTS = 13;
    localparam logic [RNG_WIDTH-1:0] RNG_SEED = 13'h000F;

endpackage

// File: rtl/rng_request_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from rr_ptr upward, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PW-1:0]      winner_idx,
    output logic               any
);

    always_comb begin : pick
        int j;
        j          = 0;
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any && req[j]) begin
                any        = 1'b1;
                winner[j]  = 1'b1;
                winner_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rng_request_arbiter.sv
// Shares one LFSR among NUM_REQ requesters, one word per round-robin grant.
// Define RNG_PREFETCH_EN to keep one pre-computed word buffered for 1-cycle grant latency.
//
// state   | meaning
// IDLE    | waiting for an eligible request (or, with prefetch, an empty buffer to refill)
// SHIFT   | lfsr_en high, stepping the LFSR SHIFTS_PER_WORD times
// CAPTURE | sample lfsr_state; grant it (or, with prefetch, park it in the buffer)
module rng_request_arbiter
    import rng_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int WIDTH           = RNG_WIDTH,
    parameter int SHIFTS_PER_WORD = RNG_SHIFTS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   lfsr_state,
    output logic               lfsr_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [WIDTH-1:0]   rnd_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(SHIFTS_PER_WORD - 1);

    rng_state_t         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic               rnd_valid_d;
    logic [WIDTH-1:0]   rnd_out_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_oh;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;

`ifdef RNG_PREFETCH_EN
    logic [WIDTH-1:0]   buf_word_q, buf_word_d;
    logic               buf_full_q, buf_full_d;
`else
    logic [PW-1:0]      winner_q, winner_d;
    logic [NUM_REQ-1:0] winner_oh_q, winner_oh_d;
`endif

    // A requester still sees its own grant pulse this cycle; don't serve it twice.
    assign eligible = req & ~gnt;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req        (eligible),
        .rr_ptr     (rr_ptr_q),
        .winner     (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            gnt         <= '0;
            rnd_valid   <= 1'b0;
            rnd_out     <= '0;
`ifdef RNG_PREFETCH_EN
            buf_word_q  <= '0;
            buf_full_q  <= 1'b0;
`else
            winner_q    <= '0;
            winner_oh_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt         <= gnt_d;
            rnd_valid   <= rnd_valid_d;
            rnd_out     <= rnd_out_d;
`ifdef RNG_PREFETCH_EN
            buf_word_q  <= buf_word_d;
            buf_full_q  <= buf_full_d;
`else
            winner_q    <= winner_d;
            winner_oh_q <= winner_oh_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_out_d   = rnd_out;
        lfsr_en     = 1'b0;
`ifdef RNG_PREFETCH_EN
        buf_word_d  = buf_word_q;
        buf_full_d  = buf_full_q;
`else
        winner_d    = winner_q;
        winner_oh_d = winner_oh_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef RNG_PREFETCH_EN
                if (buf_full_q && pick_any) begin
                    gnt_d       = pick_oh;
                    rnd_valid_d = 1'b1;
                    rnd_out_d   = buf_word_q;
                    rr_ptr_d    = next_ptr(pick_idx);
                    buf_full_d  = 1'b0;
                    cnt_d       = CNT_LOAD;
                    state_d     = SHIFT;
                end else if (!buf_full_q) begin
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end
`else
                if (pick_any) begin
                    winner_d    = pick_idx;
                    winner_oh_d = pick_oh;
                    cnt_d       = CNT_LOAD;
                    state_d     = SHIFT;
                end
`endif
            end
            SHIFT: begin
                lfsr_en = 1'b1;
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
`ifdef RNG_PREFETCH_EN
                // A waiting requester takes the fresh word directly; the buffer refills after.
                if (pick_any) begin
                    gnt_d       = pick_oh;
                    rnd_valid_d = 1'b1;
                    rnd_out_d   = lfsr_state;
                    rr_ptr_d    = next_ptr(pick_idx);
                end else begin
                    buf_word_d = lfsr_state;
                    buf_full_d = 1'b1;
                end
`else
                // Winner gave up during SHIFT: word is discarded, pointer left alone.
                if ((req & winner_oh_q) != '0) begin
                    gnt_d       = winner_oh_q;
                    rnd_valid_d = 1'b1;
                    rnd_out_d   = lfsr_state;
                    rr_ptr_d    = next_ptr(winner_q);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
